// File: rtl/seg7_scan_decoder_if.sv
// Bundle of the 7-segment scan inputs and the decoded-result handshake.
// master: the display driver / result consumer; slave: the decoder.
interface seg7_scan_decoder_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic [6:0]            seg_in;
    logic [N_DIGITS-1:0]   dig_sel;
    logic [4*N_DIGITS-1:0] bcd_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_err;
    logic                  overrun;

    modport master (
        output seg_in, dig_sel, out_ready,
        input  bcd_out, out_valid, out_err, overrun
    );

    modport slave (
        input  seg_in, dig_sel, out_ready,
        output bcd_out, out_valid, out_err, overrun
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed 7-segment scan back into an N-digit BCD value with debounce.
// Define SEG7_DEC_HEX_EN to also accept the hex glyphs A-F as valid digits.
module seg7_scan_decoder #(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_decoder_if.slave  bus_io
);
    localparam int unsigned RunW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(STABLE_CYCLES);

    // Returns {valid, value}; invalid patterns map to 4'hF.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = {1'b1, 4'h0};
            7'b0110000: r = {1'b1, 4'h1};
            7'b1101101: r = {1'b1, 4'h2};
            7'b1111001: r = {1'b1, 4'h3};
            7'b0110011: r = {1'b1, 4'h4};
            7'b1011011: r = {1'b1, 4'h5};
            7'b1011111: r = {1'b1, 4'h6};
            7'b1110000: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1111011: r = {1'b1, 4'h9};
`ifdef SEG7_DEC_HEX_EN
            7'b1110111: r = {1'b1, 4'hA};
            7'b0011111: r = {1'b1, 4'hB};
            7'b1001110: r = {1'b1, 4'hC};
            7'b0111101: r = {1'b1, 4'hD};
            7'b1001111: r = {1'b1, 4'hE};
            7'b1000111: r = {1'b1, 4'hF};
`else
`endif
            default:    r = {1'b0, 4'hF};
        endcase
        return r;
    endfunction

    logic [6:0]            s_seg_q, prev_seg_q;
    logic [N_DIGITS-1:0]   s_dig_q, prev_dig_q;
    logic [RunW-1:0]       run_q, run_d;
    logic                  cap_q, cap_d;
    logic [4*N_DIGITS-1:0] slots_q, slots_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic                  ferr_q, ferr_d;
    logic [4*N_DIGITS-1:0] bcd_q, bcd_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  ovr_q, ovr_d;

    logic [4:0] dec;
    logic       accept;

    // run_q describes the pair now held in prev_*; cap_q fires the cycle it first saturates.
    always_comb begin
        run_d = '0;
        if (!$onehot(s_dig_q)) begin
            run_d = '0;
        end else if (s_seg_q == prev_seg_q && s_dig_q == prev_dig_q) begin
            run_d = (run_q == RunMax) ? run_q : run_q + RunW'(1);
        end else begin
            run_d = RunW'(1);
        end
        cap_d = (run_d == RunMax) && (run_q != RunMax);
    end

    always_comb begin
        dec     = decode(prev_seg_q);
        accept  = valid_q & bus_io.out_ready;
        slots_d = slots_q;
        seen_d  = seen_q;
        ferr_d  = ferr_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        err_d   = err_q;
        ovr_d   = ovr_q;

        if (cap_q) begin
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                if (prev_dig_q[i]) slots_d[4*i +: 4] = dec[3:0];
            end
            seen_d = seen_q | prev_dig_q;
            ferr_d = ferr_q | ~dec[4];
        end

        if (cap_q && (&seen_d)) begin
            if (!valid_q || accept) begin
                bcd_d   = slots_d;
                err_d   = ferr_d;
                valid_d = 1'b1;
                ovr_d   = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
            seen_d = '0;
            ferr_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg_q    <= '0;
            s_dig_q    <= '0;
            prev_seg_q <= '0;
            prev_dig_q <= '0;
            run_q      <= '0;
            cap_q      <= 1'b0;
            slots_q    <= '0;
            seen_q     <= '0;
            ferr_q     <= 1'b0;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            s_seg_q    <= bus_io.seg_in;
            s_dig_q    <= bus_io.dig_sel;
            prev_seg_q <= s_seg_q;
            prev_dig_q <= s_dig_q;
            run_q      <= run_d;
            cap_q      <= cap_d;
            slots_q    <= slots_d;
            seen_q     <= seen_d;
            ferr_q     <= ferr_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus_io.bcd_out   = bcd_q;
    assign bus_io.out_valid = valid_q;
    assign bus_io.out_err   = err_q;
    assign bus_io.overrun   = ovr_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (N_DIGITS=4, STABLE_CYCLES=4).
module tb_seg7_scan_decoder;
    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;
`ifdef SEG7_DEC_HEX_EN
    localparam logic [6:0]  PBAD    = 7'b1110111;
    localparam logic [15:0] BAD_BCD = 16'h8A88;
    localparam logic        BAD_ERR = 1'b0;
`else
    localparam logic [6:0]  PBAD    = 7'b0000000;
    localparam logic [15:0] BAD_BCD = 16'h8F88;
    localparam logic        BAD_ERR = 1'b1;
`endif

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    seg7_scan_decoder_if #(.N_DIGITS(4)) bus ();

    seg7_scan_decoder #(
        .N_DIGITS      (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] pat, input int n);
        bus.dig_sel = sel;
        bus.seg_in  = pat;
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept_one();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.seg_in    = '0;
        bus.dig_sel   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("reset_bcd", bus.bcd_out, 16'h0);
        chk("reset_valid", 16'(bus.out_valid), 16'h0);
        chk("reset_err", 16'(bus.out_err), 16'h0);
        chk("reset_ovr", 16'(bus.overrun), 16'h0);
        rst = 1'b0;
        step();

        // Basic decode with latency on the completing digit
        bus.out_ready = 1'b1;
        drive(4'b0001, P3, 6);
        drive(4'b0010, P0, 6);
        drive(4'b0100, P2, 6);
        drive(4'b1000, P1, 5);
        chk("basic_not_early", 16'(bus.out_valid), 16'h0);
        step();
        chk("basic_valid", 16'(bus.out_valid), 16'h1);
        chk("basic_bcd", bus.bcd_out, 16'h1203);
        chk("basic_err", 16'(bus.out_err), 16'h0);
        step();
        chk("basic_pulse_end", 16'(bus.out_valid), 16'h0);
        bus.out_ready = 1'b0;

        // Debounce: 5 bounces into 6; a 3-cycle dwell on digit 3 must not capture
        drive(4'b0001, P5, 3);
        drive(4'b0001, P6, 5);
        drive(4'b0010, P0, 6);
        drive(4'b0100, P0, 6);
        drive(4'b1000, P7, 3);
        drive(4'b0000, P0, 8);
        chk("short_dwell_nocap", 16'(bus.out_valid), 16'h0);
        drive(4'b1000, P7, 6);
        chk("debounce_valid", 16'(bus.out_valid), 16'h1);
        chk("debounce_bcd", bus.bcd_out, 16'h7006);
        accept_one();
        chk("debounce_accept", 16'(bus.out_valid), 16'h0);

        // Invalid (or hex) pattern in digit 2
        drive(4'b0001, P8, 6);
        drive(4'b0010, P8, 6);
        drive(4'b0100, PBAD, 6);
        drive(4'b1000, P8, 6);
        chk("bad_valid", 16'(bus.out_valid), 16'h1);
        chk("bad_bcd", bus.bcd_out, BAD_BCD);
        chk("bad_err", 16'(bus.out_err), 16'(BAD_ERR));
        chk("bad_ovr", 16'(bus.overrun), 16'h0);
        accept_one();
        chk("bad_accept", 16'(bus.out_valid), 16'h0);

        // Backpressure: second frame dropped
        for (int i = 0; i < 4; i++) drive(4'(1 << i), P1, 6);
        chk("bp_first_bcd", bus.bcd_out, 16'h1111);
        for (int i = 0; i < 4; i++) drive(4'(1 << i), P2, 6);
        chk("bp_hold_valid", 16'(bus.out_valid), 16'h1);
        chk("bp_hold_bcd", bus.bcd_out, 16'h1111);
        chk("bp_overrun", 16'(bus.overrun), 16'h1);
        accept_one();
        chk("bp_accept_valid", 16'(bus.out_valid), 16'h0);
        chk("bp_accept_ovr", 16'(bus.overrun), 16'h0);

        // Accept on the same edge a new frame loads
        for (int i = 0; i < 4; i++) drive(4'(1 << i), P5, 6);
        drive(4'b1000, P9, 6);
        drive(4'b0100, P8, 6);
        drive(4'b0010, P7, 6);
        drive(4'b0001, P6, 5);
        chk("sim_pending_bcd", bus.bcd_out, 16'h5555);
        accept_one();
        chk("sim_valid", 16'(bus.out_valid), 16'h1);
        chk("sim_bcd", bus.bcd_out, 16'h9876);
        chk("sim_ovr", 16'(bus.overrun), 16'h0);
        accept_one();
        chk("sim_accept", 16'(bus.out_valid), 16'h0);

        // Multi-hot strobe never captures; reset discards partial frame
        drive(4'b0011, P8, 10);
        drive(4'b0010, P3, 6);
        drive(4'b0100, P3, 6);
        drive(4'b1000, P3, 6);
        drive(4'b0000, P0, 4);
        chk("multihot_nocap", 16'(bus.out_valid), 16'h0);
        rst = 1'b1;
        #1;
        chk("midrst_bcd", bus.bcd_out, 16'h0);
        chk("midrst_valid", 16'(bus.out_valid), 16'h0);
        chk("midrst_err", 16'(bus.out_err), 16'h0);
        chk("midrst_ovr", 16'(bus.overrun), 16'h0);
        step();
        rst = 1'b0;
        drive(4'b0001, P4, 6);
        drive(4'b0000, P0, 6);
        chk("post_rst_partial", 16'(bus.out_valid), 16'h0);
        drive(4'b0010, P5, 6);
        drive(4'b0100, P5, 6);
        drive(4'b1000, P5, 6);
        chk("post_rst_valid", 16'(bus.out_valid), 16'h1);
        chk("post_rst_bcd", bus.bcd_out, 16'h5554);
        chk("post_rst_err", 16'(bus.out_err), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
